// File: rtl/sdft_sched_if.sv
// Signal bundle between the sDFT scheduler, the ADC/sDFT core and the frequency BRAM write port.
// With SDFT_SCHED_PEAK_EN defined the bundle also carries the per-sweep peak bin and magnitude.
interface sdft_sched_if #(
    parameter int data_width = 8,
    parameter int freq_w     = 12,
    parameter int bin_addr_w = 6
);
    logic                     [data_width-1:0] adc;
    logic                     [data_width-1:0] sample;
    logic                                      fft_start;
    logic                                      fft_ready;
    logic                                      fft_read;
    logic                     [bin_addr_w-1:0] bin_addr;
    logic signed              [freq_w-1:0]     bin_real;
    logic signed              [freq_w-1:0]     bin_imag;
    logic                                      bram_w_en;
    logic                     [bin_addr_w-1:0] bram_w_addr;
    logic                     [freq_w-1:0]     bram_w_data;
    logic                                      sweep_done;
    logic                                      busy;
`ifdef SDFT_SCHED_PEAK_EN
    logic                     [bin_addr_w-1:0] peak_bin;
    logic                     [freq_w-1:0]     peak_mag;

    modport master (
        input  adc, fft_ready, bin_real, bin_imag,
        output sample, fft_start, fft_read, bin_addr,
        output bram_w_en, bram_w_addr, bram_w_data, sweep_done, busy,
        output peak_bin, peak_mag
    );

    modport slave (
        output adc, fft_ready, bin_real, bin_imag,
        input  sample, fft_start, fft_read, bin_addr,
        input  bram_w_en, bram_w_addr, bram_w_data, sweep_done, busy,
        input  peak_bin, peak_mag
    );
`else
    modport master (
        input  adc, fft_ready, bin_real, bin_imag,
        output sample, fft_start, fft_read, bin_addr,
        output bram_w_en, bram_w_addr, bram_w_data, sweep_done, busy
    );

    modport slave (
        output adc, fft_ready, bin_real, bin_imag,
        input  sample, fft_start, fft_read, bin_addr,
        input  bram_w_en, bram_w_addr, bram_w_data, sweep_done, busy
    );
`endif
endinterface

// File: rtl/sdft_sched.sv
// Sample-capture and readout scheduler for a sliding-DFT core: feeds ADC samples, then every
// read_period samples sweeps all bins into a magnitude BRAM. Optional peak tracking: SDFT_SCHED_PEAK_EN.
module sdft_sched #(
    parameter int data_width  = 8,
    parameter int freq_bins   = 64,
    parameter int freq_w      = 12,
    parameter int bin_addr_w  = 6,
    parameter int read_period = 100,
    parameter int mag_shift   = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    sdft_sched_if.master bus
);

    typedef enum logic [2:0] {
        WAIT_READY,
        WAIT_ACCEPT,
        WAIT_DONE,
        SWEEP_ADDR,
        SWEEP_WRITE
    } state_t;

    localparam int CNT_W = (read_period > 1) ? $clog2(read_period) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(read_period - 1);
    localparam logic [bin_addr_w-1:0] BIN_LAST = bin_addr_w'(freq_bins - 1);
    localparam logic [2*freq_w:0]     MAG_MAX  = {{(freq_w + 1){1'b0}}, {freq_w{1'b1}}};

    state_t                  r_state, w_state_next;
    logic [data_width-1:0]   r_sample, w_sample_next;
    logic                    r_fft_start, w_fft_start_next;
    logic                    r_fft_read, w_fft_read_next;
    logic [bin_addr_w-1:0]   r_bin_addr, w_bin_addr_next;
    logic [CNT_W-1:0]        r_sample_cnt, w_sample_cnt_next;
    logic                    r_w_en, w_w_en_next;
    logic [bin_addr_w-1:0]   r_w_addr, w_w_addr_next;
    logic [freq_w-1:0]       r_w_data, w_w_data_next;
    logic                    r_last, w_last_next;
    logic                    r_sweep_done;

    // Operands are sign-extended to the product width so (-2**(freq_w-1))**2 cannot wrap.
    logic signed [2*freq_w-1:0] w_re_ext, w_im_ext;
    logic signed [2*freq_w-1:0] w_re_sq, w_im_sq;
    logic        [2*freq_w:0]   w_sum, w_sum_shr;
    logic        [freq_w-1:0]   w_mag;

    assign w_re_ext  = {{freq_w{bus.bin_real[freq_w-1]}}, bus.bin_real};
    assign w_im_ext  = {{freq_w{bus.bin_imag[freq_w-1]}}, bus.bin_imag};
    assign w_re_sq   = w_re_ext * w_re_ext;
    assign w_im_sq   = w_im_ext * w_im_ext;
    assign w_sum     = {1'b0, w_re_sq} + {1'b0, w_im_sq};
    assign w_sum_shr = w_sum >> mag_shift;
    assign w_mag     = (w_sum_shr > MAG_MAX) ? {freq_w{1'b1}} : w_sum_shr[freq_w-1:0];

    always_comb begin
        w_state_next      = r_state;
        w_sample_next     = r_sample;
        w_fft_start_next  = r_fft_start;
        w_fft_read_next   = r_fft_read;
        w_bin_addr_next   = r_bin_addr;
        w_sample_cnt_next = r_sample_cnt;
        w_w_en_next       = 1'b0;
        w_w_addr_next     = r_w_addr;
        w_w_data_next     = r_w_data;
        w_last_next       = 1'b0;
        case (r_state)
            WAIT_READY: begin
                if (bus.fft_ready) begin
                    w_sample_next    = bus.adc;
                    w_fft_start_next = 1'b1;
                    w_state_next     = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                if (!bus.fft_ready) begin
                    w_fft_start_next = 1'b0;
                    w_state_next     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.fft_ready) begin
                    if (r_sample_cnt == CNT_LAST) begin
                        w_sample_cnt_next = '0;
                        w_bin_addr_next   = '0;
                        w_fft_read_next   = 1'b1;
                        w_state_next      = SWEEP_ADDR;
                    end else begin
                        w_sample_cnt_next = r_sample_cnt + 1'b1;
                        w_state_next      = WAIT_READY;
                    end
                end
            end
            SWEEP_ADDR: begin
                // Core returns the bin one cycle after the address; it is consumed in SWEEP_WRITE.
                w_state_next = SWEEP_WRITE;
            end
            SWEEP_WRITE: begin
                w_w_en_next   = 1'b1;
                w_w_addr_next = r_bin_addr;
                w_w_data_next = w_mag;
                if (r_bin_addr == BIN_LAST) begin
                    w_bin_addr_next = '0;
                    w_last_next     = 1'b1;
                    w_fft_read_next = 1'b0;
                    w_state_next    = WAIT_READY;
                end else begin
                    w_bin_addr_next = r_bin_addr + 1'b1;
                    w_state_next    = SWEEP_ADDR;
                end
            end
            default: begin
                w_state_next = WAIT_READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= WAIT_READY;
            r_sample     <= '0;
            r_fft_start  <= 1'b0;
            r_fft_read   <= 1'b0;
            r_bin_addr   <= '0;
            r_sample_cnt <= '0;
            r_w_en       <= 1'b0;
            r_w_addr     <= '0;
            r_w_data     <= '0;
            r_last       <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sample     <= w_sample_next;
            r_fft_start  <= w_fft_start_next;
            r_fft_read   <= w_fft_read_next;
            r_bin_addr   <= w_bin_addr_next;
            r_sample_cnt <= w_sample_cnt_next;
            r_w_en       <= w_w_en_next;
            r_w_addr     <= w_w_addr_next;
            r_w_data     <= w_w_data_next;
            r_last       <= w_last_next;
            // Done follows the final BRAM write by one cycle.
            r_sweep_done <= r_last;
        end
    end

    assign bus.sample      = r_sample;
    assign bus.fft_start   = r_fft_start;
    assign bus.fft_read    = r_fft_read;
    assign bus.bin_addr    = r_bin_addr;
    assign bus.bram_w_en   = r_w_en;
    assign bus.bram_w_addr = r_w_addr;
    assign bus.bram_w_data = r_w_data;
    assign bus.sweep_done  = r_sweep_done;
    assign bus.busy        = (r_state != WAIT_READY);

`ifdef SDFT_SCHED_PEAK_EN
    logic [bin_addr_w-1:0] r_run_bin, r_peak_bin;
    logic [freq_w-1:0]     r_run_mag, r_peak_mag;
    logic                  w_take;

    // Strict compare keeps the lowest index on ties; bin 0 always seeds the running max.
    assign w_take = r_w_en && ((r_w_addr == '0) || (r_w_data > r_run_mag));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_run_bin  <= '0;
            r_run_mag  <= '0;
            r_peak_bin <= '0;
            r_peak_mag <= '0;
        end else begin
            if (w_take) begin
                r_run_bin <= r_w_addr;
                r_run_mag <= r_w_data;
            end
            if (r_last) begin
                r_peak_bin <= w_take ? r_w_addr : r_run_bin;
                r_peak_mag <= w_take ? r_w_data : r_run_mag;
            end
        end
    end

    assign bus.peak_bin = r_peak_bin;
    assign bus.peak_mag = r_peak_mag;
`endif

endmodule

// File: tb/tb_sdft_sched.sv
// Directed bench for sdft_sched (read_period=4, freq_bins=4): capture handshake, sweep timing,
// magnitude/saturation values and mid-sweep reset. Peak outputs checked when SDFT_SCHED_PEAK_EN is set.
module tb_sdft_sched;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    sdft_sched_if #(.data_width(8), .freq_w(12), .bin_addr_w(2)) bus ();

    sdft_sched #(
        .data_width (8),
        .freq_bins  (4),
        .freq_w     (12),
        .bin_addr_w (2),
        .read_period(4),
        .mag_shift  (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: bin components appear one cycle after the address.
    logic signed [11:0] re_tab [4];
    logic signed [11:0] im_tab [4];
    int                 exp_mag [4];
    logic [1:0]         addr_q = 2'd0;

    always @(posedge clk) addr_q <= bus.bin_addr;
    assign bus.bin_real = re_tab[addr_q];
    assign bus.bin_imag = im_tab[addr_q];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.fft_read === 1'b1) check("start_in_sweep", bus.fft_start, 0);
    end

    task automatic load_table(input int set);
        if (set == 0) begin
            re_tab[0] = 12'sd16;    im_tab[0] = -12'sd16;   exp_mag[0] = 2;
            re_tab[1] = -12'sd2048; im_tab[1] = -12'sd2048; exp_mag[1] = 4095;
            re_tab[2] = 12'sd100;   im_tab[2] = 12'sd0;     exp_mag[2] = 39;
            re_tab[3] = 12'sd0;     im_tab[3] = -12'sd1000; exp_mag[3] = 3906;
        end else begin
            re_tab[0] = 12'sd28;    im_tab[0] = 12'sd0;     exp_mag[0] = 3;
            re_tab[1] = 12'sd48;    im_tab[1] = 12'sd0;     exp_mag[1] = 9;
            re_tab[2] = 12'sd0;     im_tab[2] = -12'sd48;   exp_mag[2] = 9;
            re_tab[3] = 12'sd0;     im_tab[3] = 12'sd16;    exp_mag[3] = 1;
        end
    endtask

    // Entered at a negedge with the DUT in WAIT_READY.
    task automatic do_sample(input logic [7:0] val, input int hold, input bit last);
        bus.adc       = val;
        bus.fft_ready = 1'b1;
        @(negedge clk);
        check("sample", bus.sample, val);
        check("start_set", bus.fft_start, 1);
        check("busy_accept", bus.busy, 1);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check("start_hold", bus.fft_start, 1);
        end
        bus.fft_ready = 1'b0;
        @(negedge clk);
        check("start_clr", bus.fft_start, 0);
        check("busy_done", bus.busy, 1);
        bus.fft_ready = 1'b1;
        @(negedge clk);
        if (last) begin
            check("read_begin", bus.fft_read, 1);
            check("addr_begin", bus.bin_addr, 0);
        end else begin
            check("busy_idle", bus.busy, 0);
            check("read_idle", bus.fft_read, 0);
        end
        bus.fft_ready = 1'b0;
        $display("sample adc=0x%02h hold=%0d sweep=%0d", val, hold, last);
    endtask

    // Entered at the negedge of SWEEP_ADDR for bin 0.
    task automatic do_sweep(input bit abort_at2, input int exp_pbin, input int exp_pmag);
        for (int b = 0; b < 4; b++) begin
            check("sweep_addr", bus.bin_addr, b);
            check("read_addr", bus.fft_read, 1);
            if (b == 0) begin
                check("wen_first", bus.bram_w_en, 0);
            end else begin
                check("wen", bus.bram_w_en, 1);
                check("waddr", bus.bram_w_addr, b - 1);
                check("wdata", bus.bram_w_data, exp_mag[b-1]);
                $display("bin %0d written data=%0d", b - 1, bus.bram_w_data);
            end
            @(negedge clk);
            check("wen_write_phase", bus.bram_w_en, 0);
            check("read_write", bus.fft_read, 1);
            check("done_mid", bus.sweep_done, 0);
            if (abort_at2 && b == 2) begin
                reset_n = 1'b0;
                $display("reset asserted during bin 2");
                return;
            end
            @(negedge clk);
        end
        check("wen_last", bus.bram_w_en, 1);
        check("waddr_last", bus.bram_w_addr, 3);
        check("wdata_last", bus.bram_w_data, exp_mag[3]);
        check("read_end", bus.fft_read, 0);
        check("busy_end", bus.busy, 0);
        check("done_early", bus.sweep_done, 0);
        $display("bin 3 written data=%0d", bus.bram_w_data);
        @(negedge clk);
        check("done_pulse", bus.sweep_done, 1);
        check("wen_after", bus.bram_w_en, 0);
`ifdef SDFT_SCHED_PEAK_EN
        check("peak_bin", bus.peak_bin, exp_pbin);
        check("peak_mag", bus.peak_mag, exp_pmag);
`endif
        @(negedge clk);
        check("done_clear", bus.sweep_done, 0);
        $display("sweep done expected peak bin=%0d mag=%0d", exp_pbin, exp_pmag);
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_sample"}, bus.sample, 0);
        check({phase, "_start"}, bus.fft_start, 0);
        check({phase, "_read"}, bus.fft_read, 0);
        check({phase, "_busy"}, bus.busy, 0);
        check({phase, "_wen"}, bus.bram_w_en, 0);
        check({phase, "_waddr"}, bus.bram_w_addr, 0);
        check({phase, "_wdata"}, bus.bram_w_data, 0);
        check({phase, "_done"}, bus.sweep_done, 0);
        check({phase, "_binaddr"}, bus.bin_addr, 0);
`ifdef SDFT_SCHED_PEAK_EN
        check({phase, "_peak_bin"}, bus.peak_bin, 0);
        check({phase, "_peak_mag"}, bus.peak_mag, 0);
`endif
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.adc       = 8'h00;
        bus.fft_ready = 1'b0;
        load_table(0);
        repeat (2) @(negedge clk);
        // fft_ready high while in reset must not start a capture
        bus.fft_ready = 1'b1;
        bus.adc       = 8'hA5;
        @(negedge clk);
        check_all_zero("reset");
        $display("reset state checked");
        bus.fft_ready = 1'b0;
        reset_n       = 1'b1;
        @(negedge clk);
        check("idle_after_reset", bus.busy, 0);

        do_sample(8'h5A, 3, 1'b0);
        do_sample(8'h11, 1, 1'b0);
        do_sample(8'h22, 1, 1'b0);
        do_sample(8'h33, 2, 1'b1);
        do_sweep(1'b0, 1, 4095);

        load_table(1);
        do_sample(8'h44, 1, 1'b0);
        do_sample(8'h55, 1, 1'b0);
        do_sample(8'h66, 1, 1'b0);
        do_sample(8'h77, 1, 1'b1);
        do_sweep(1'b0, 1, 9);

        do_sample(8'h01, 1, 1'b0);
        do_sample(8'h02, 1, 1'b0);
        do_sample(8'h03, 1, 1'b0);
        do_sample(8'h04, 1, 1'b1);
        do_sweep(1'b1, 0, 0);
        @(negedge clk);
        check_all_zero("abort");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_abort", bus.sweep_done, 0);
        end

        do_sample(8'h81, 1, 1'b0);
        do_sample(8'h82, 1, 1'b0);
        do_sample(8'h83, 1, 1'b0);
        do_sample(8'h84, 1, 1'b1);
        do_sweep(1'b0, 1, 9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
